// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, sizes and big-endian byte helpers for dmem_responder
package dmem_pkg;
    localparam int DMEM_MEM_WIDTH = 8;
    localparam int DMEM_WORD_WIDTH = 32;
    localparam int DMEM_DEPTH = 1024;
    localparam int BYTES_PER_WORD = DMEM_WORD_WIDTH / DMEM_MEM_WIDTH;
    localparam int OFF_W = $clog2(BYTES_PER_WORD);
    localparam int IDX_W = $clog2(DMEM_DEPTH) - OFF_W;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic valid;
        logic [IDX_W-1:0] idx;
        logic [DMEM_WORD_WIDTH-1:0] data;
    } wb_entry_t;
    function automatic logic [DMEM_MEM_WIDTH-1:0] be_byte(input logic [DMEM_WORD_WIDTH-1:0] w, input int k);
        return w[DMEM_WORD_WIDTH-1-k*DMEM_MEM_WIDTH -: DMEM_MEM_WIDTH];
    endfunction
    function automatic logic [DMEM_WORD_WIDTH-1:0] be_insert(input logic [DMEM_WORD_WIDTH-1:0] w, input int k,
                                                             input logic [DMEM_MEM_WIDTH-1:0] b);
        logic [DMEM_WORD_WIDTH-1:0] r;
        r = w;
        r[DMEM_WORD_WIDTH-1-k*DMEM_MEM_WIDTH -: DMEM_MEM_WIDTH] = b;
        return r;
    endfunction
endpackage

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: circular store FIFO; youngest-match lookup port exists only under WB_FORWARD_EN
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    localparam int PW = $clog2(WB_DEPTH),
    localparam int CW = $clog2(WB_DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic [DMEM_WORD_WIDTH-1:0] push_data,
    input  logic pop,
`ifdef WB_FORWARD_EN
    input  logic [IDX_W-1:0] lookup_idx,
    output logic hit,
    output logic [DMEM_WORD_WIDTH-1:0] hit_data,
`endif
    output wb_entry_t head,
    output logic full,
    output logic empty,
    output logic [CW-1:0] count
);
    wb_entry_t entries [WB_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign head = entries[rd_ptr];
    assign full = count == CW'(WB_DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    // FIFO state; full is judged on current occupancy so a same-cycle pop never makes room for a push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < WB_DEPTH; i++) entries[i] <= '0;
        end else begin
            if (do_pop) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                entries[wr_ptr] <= '{valid: 1'b1, idx: push_idx, data: push_data};
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
`ifdef WB_FORWARD_EN
    // scan oldest to youngest so the youngest matching entry wins
    always_comb begin
        hit = 1'b0;
        hit_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (entries[rd_ptr + PW'(k)].valid && entries[rd_ptr + PW'(k)].idx == lookup_idx) begin
                hit = 1'b1;
                hit_data = entries[rd_ptr + PW'(k)].data;
            end
        end
    end
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with store write buffer and fixed-latency loads; WB_FORWARD_EN enables buffer-hit forwarding
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WIDTH = DMEM_MEM_WIDTH,
    parameter int WORD_WIDTH = DMEM_WORD_WIDTH,
    parameter int DEPTH = DMEM_DEPTH,
    parameter int MEM_ADDR_SIZE = 32,
    parameter int WB_DEPTH = 4,
    parameter int RD_LATENCY = 2,
    localparam int CW = $clog2(WB_DEPTH + 1),
    localparam int LW = $clog2(RD_LATENCY + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic [MEM_ADDR_SIZE-1:0] addr,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic read_valid,
    output logic stall,
    output logic err,
    output logic [CW-1:0] wb_count
);
    logic [MEM_WIDTH-1:0] mem [DEPTH];
    state_t state, state_n;
    logic [LW-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] req_idx, busy_idx, rd_idx;
    logic [WORD_WIDTH-1:0] rd_word, read_data_n, hit_data;
    logic read_valid_n, hit, full, empty, accept, drop, load_ok, store_ok, addr_unused;
    wb_entry_t head;
    assign req_idx = addr[AW-1:OFF_W];
    assign addr_unused = ^addr[MEM_ADDR_SIZE-1:AW];
    assign stall = (state == BUSY) | (mem_write && full)
`ifndef WB_FORWARD_EN
        | (mem_read && wb_count != '0)
`endif
        ;
    assign accept = (mem_read || mem_write) && !stall;
    assign drop = accept && ((mem_read && mem_write) || addr[OFF_W-1:0] != '0);
    assign load_ok = accept && mem_read && !drop;
    assign store_ok = accept && mem_write && !drop;
    assign rd_idx = state == BUSY ? busy_idx : req_idx;
    dmem_write_buffer #(.WB_DEPTH(WB_DEPTH)) u_wb (
        .clk(clk),
        .reset(reset),
        .push(store_ok),
        .push_idx(req_idx),
        .push_data(write_data),
        .pop(!empty),
`ifdef WB_FORWARD_EN
        .lookup_idx(req_idx),
        .hit(hit),
        .hit_data(hit_data),
`endif
        .head(head),
        .full(full),
        .empty(empty),
        .count(wb_count)
    );
`ifndef WB_FORWARD_EN
    assign hit = 1'b0;
    assign hit_data = '0;
`endif
    // assemble the big-endian storage word at the active read index
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) rd_word = be_insert(rd_word, k, mem[{rd_idx, OFF_W'(k)}]);
    end
    // drain the buffer head into storage, one word per cycle, independent of reads
    always_ff @(posedge clk) begin
        if (head.valid)
            for (int k = 0; k < BYTES_PER_WORD; k++) mem[{head.idx, OFF_W'(k)}] <= be_byte(head.data, k);
    end
    // load FSM: hits and single-cycle misses answer next cycle, longer misses wait out the counter in BUSY
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        read_valid_n = 1'b0;
        read_data_n = read_data;
        if (state == BUSY) begin
            cnt_n = cnt - 1'b1;
            if (cnt == LW'(1)) begin
                state_n = IDLE;
                read_valid_n = 1'b1;
                read_data_n = rd_word;
            end
        end else if (load_ok) begin
            if (hit || RD_LATENCY == 1) begin
                read_valid_n = 1'b1;
                read_data_n = hit ? hit_data : rd_word;
            end else begin
                state_n = BUSY;
                cnt_n = LW'(RD_LATENCY - 1);
            end
        end
    end
    // FSM and response registers; reset abandons any in-flight load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            busy_idx <= '0;
            read_data <= '0;
            read_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            read_data <= read_data_n;
            read_valid <= read_valid_n;
            err <= drop;
            if (load_ok) busy_idx <= req_idx;
        end
    end
endmodule
